// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with sequential post-reset clear; define REGFILE_BYPASS_EN for write-to-read forwarding
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
module regfile_mp #(
    parameter int WIDTH       = `WORD_WIDTH,
    parameter int REG_COUNT   = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int ZERO_REG    = 1,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  raddr,
    output logic [READ_PORTS*WIDTH-1:0]       rdata,
    input  logic [WRITE_PORTS-1:0]            we,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] waddr,
    input  logic [WRITE_PORTS*WIDTH-1:0]      wdata,
    output logic                              ready
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic [WIDTH-1:0]      regs [REG_COUNT];

    function automatic logic usable(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < REG_COUNT) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign ready = (state == RUN);

    // clear one entry per cycle after reset, then accept writes (later ports override earlier ones)
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            regs[clr_idx] <= '0;
            clr_idx       <= clr_idx + 1'b1;
            if (32'(clr_idx) == REG_COUNT - 1)
                state <= RUN;
        end else begin
            for (int j = 0; j < WRITE_PORTS; j++)
                if (we[j] && usable(waddr[j*ADDR_WIDTH +: ADDR_WIDTH]))
                    regs[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*WIDTH +: WIDTH];
        end
    end

    // combinational reads; zero while clearing or for unusable addresses
    always_comb begin
        rdata = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            rdata[i*WIDTH +: WIDTH] = (state == RUN && usable(raddr[i*ADDR_WIDTH +: ADDR_WIDTH]))
                                    ? regs[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < WRITE_PORTS; j++)
                if (state == RUN && we[j] && usable(waddr[j*ADDR_WIDTH +: ADDR_WIDTH])
                    && waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr[i*ADDR_WIDTH +: ADDR_WIDTH])
                    rdata[i*WIDTH +: WIDTH] = wdata[j*WIDTH +: WIDTH];
`endif
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp (24 regs, 2 read, 2 write ports)
module tb_regfile_mp;
    localparam int W  = 32;
    localparam int RC = 24;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [RP*AW-1:0]  raddr = '0;
    logic [RP*W-1:0]   rdata;
    logic [WP-1:0]     we = '0;
    logic [WP*AW-1:0]  waddr = '0;
    logic [WP*W-1:0]   wdata = '0;
    logic              ready;

    regfile_mp #(.WIDTH(W), .REG_COUNT(RC), .READ_PORTS(RP), .WRITE_PORTS(WP), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [63:0] rd;
    } exp_t;

    exp_t        q[$];
    int unsigned mem[RC];
    int          since = 0;
    int          checks = 0;
    int          passed = 0;

    // reference: value a reader should see this cycle
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (since < RC || int'(a) >= RC || a == 0) return 32'd0;
        v = mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < WP; j++)
            if (we[j] && waddr[j*AW +: AW] == a) v = wdata[j*W +: W];
`endif
        return v;
    endfunction

    task automatic step(input logic r, input logic [1:0] w, input logic [9:0] wa,
                        input logic [63:0] wd, input logic [9:0] ra);
        logic [4:0] a;
        rst = r; we = w; waddr = wa; wdata = wd; raddr = ra;
        q.push_back('{since >= RC, {exp_rd(ra[9:5]), exp_rd(ra[4:0])}});
        @(posedge clk);
        if (r) begin
            since = 0;
            foreach (mem[k]) mem[k] = 0;
        end else begin
            if (since >= RC)
                for (int j = 0; j < WP; j++) begin
                    a = wa[j*AW +: AW];
                    if (w[j] && int'(a) < RC && a != 0) mem[a] = wd[j*W +: W];
                end
            if (since < RC) since++;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++)
            step(r, 2'b00, 10'($urandom), {$urandom, $urandom}, 10'($urandom));
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a += 2)
            step(1'b0, 2'b00, 10'd0, 64'd0, {5'(a + 1), 5'(a)});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // monitor: compare every presented output against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ready", {31'd0, ready}, {31'd0, e.rdy});
            chk("rdata0", rdata[31:0], e.rd[31:0]);
            chk("rdata1", rdata[63:32], e.rd[63:32]);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        idle(3, 1'b1);
        idle(RC + 2, 1'b0);
        read_all();
        idle(1, 1'b1);
        idle(10, 1'b0);
        idle(1, 1'b1);
        idle(RC + 4, 1'b0);
        step(1'b0, 2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, {5'd5, 5'd5});
        step(1'b0, 2'b00, 10'd0, 64'd0, {5'd0, 5'd5});
        step(1'b0, 2'b01, {5'd0, 5'd0}, {32'd0, 32'h1234}, {5'd0, 5'd0});
        step(1'b0, 2'b00, 10'd0, 64'd0, {5'd5, 5'd0});
        step(1'b0, 2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, {5'd7, 5'd7});
        step(1'b0, 2'b00, 10'd0, 64'd0, {5'd7, 5'd7});
        step(1'b0, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h5}, {5'd0, 5'd0});
        step(1'b0, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h9}, {5'd3, 5'd3});
        step(1'b0, 2'b00, 10'd0, 64'd0, {5'd3, 5'd3});
        step(1'b0, 2'b10, {5'd25, 5'd0}, {32'hABCD, 32'd0}, {5'd25, 5'd25});
        read_all();
        idle(1, 1'b1);
        for (int k = 0; k < RC; k++)
            step(1'b0, 2'b11, 10'($urandom), {$urandom, $urandom}, 10'($urandom));
        read_all();
        for (int k = 0; k < 600; k++)
            step($urandom_range(99) == 0, 2'($urandom), 10'($urandom), {$urandom, $urandom}, 10'($urandom));
        read_all();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
